panel_snapshot_reader: RTL and testbench

Serialises a snapshot of the board's seven-segment digit bus and LED bus to a low-pin-count host link, one slot per host step strobe. Generalises the fixed 16-digit/16-LED reader: digit count, digit width, LED count, idle timeout and synchroniser depth are parameters. It adds frame wrap-around with automatic re-capture, plus explicit valid/last/busy status. It sits between the user-design output capture and the board-to-host readout pins.

---
 rtl/panel_reader_pkg.sv | 49 ++++
 rtl/step_edge_sync.sv | 27 ++
 rtl/panel_snapshot_reader.sv | 95 +++++++++
 tb/tb_panel_snapshot_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_reader_pkg.sv
// Shared constants and helpers for the panel snapshot reader.
// Slot extraction works on zero-extended buses so one function fits every size.
package panel_reader_pkg;

  localparam int DEF_NUM_DIGITS   = 16;
  localparam int DEF_DIGIT_W      = 4;
  localparam int DEF_NUM_LEDS     = 16;
  localparam int DEF_IDLE_TIMEOUT = 10_000_000;
  localparam int DEF_SYNC_STAGES  = 2;

  localparam int MAX_SEG_W   = 1024;
  localparam int MAX_LEDS    = 256;
  localparam int MAX_DIGIT_W = 32;

  typedef logic [MAX_SEG_W-1:0] seg_wide_t;
  typedef logic [MAX_LEDS-1:0]  led_wide_t;
  typedef logic [MAX_DIGIT_W:0] slot_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_w(input int n);
    return max_int(1, $clog2(n));
  endfunction

  // {digit, led bit}; slot k reads digit/led from the MSB end
  function automatic slot_t slot_bits(
    input seg_wide_t sg,
    input led_wide_t ld,
    input int        k,
    input int        nd,
    input int        dw,
    input int        nl
  );
    logic [MAX_DIGIT_W-1:0] mask;
    logic [MAX_DIGIT_W-1:0] dig;
    logic                   b;
    mask = (MAX_DIGIT_W'(1) << dw) - MAX_DIGIT_W'(1);
    dig  = '0;
    b    = 1'b0;
    if (k < nd)
      dig = MAX_DIGIT_W'(sg >> ((nd - 1 - k) * dw)) & mask;
    if (k < nl)
      b = |((ld >> (nl - 1 - k)) & led_wide_t'(1));
    return {dig, b};
  endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Synchronises the host step strobe and emits a one-cycle
// registered pulse on each rising edge.
module step_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      pulse  <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/panel_snapshot_reader.sv
// Serialises a captured seven-segment/LED snapshot one slot per
// host step, with wrap-around recapture and an idle timeout.
module panel_snapshot_reader
  import panel_reader_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DIGIT_W      = DEF_DIGIT_W,
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic                          clk_100mhz,
  input  logic                          rst_n,
  input  logic                          step,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] seg,
  input  logic [NUM_LEDS-1:0]           led,
  output logic [DIGIT_W:0]              data,
  output logic [idx_w(max_int(NUM_DIGITS, NUM_LEDS))-1:0] s,
  output logic                          valid,
  output logic                          last,
  output logic                          busy
);

  localparam int NSLOTS = max_int(NUM_DIGITS, NUM_LEDS);
  localparam int IDX_W  = idx_w(NSLOTS);
  localparam int SEG_W  = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOTS - 1);

  logic                step_p;
  logic                capture;
  logic [SEG_W-1:0]    sh_seg;
  logic [NUM_LEDS-1:0] sh_led;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    s_next;
  logic [DIGIT_W:0]    cap_slot;
  logic [DIGIT_W:0]    adv_slot;

  step_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .din   (step),
    .pulse (step_p)
  );

  assign capture = !busy || last;
  assign s_next  = s + IDX_W'(1);

  // Slot 0 of a capture comes straight from the live buses being latched
  assign cap_slot = (DIGIT_W+1)'(slot_bits(seg_wide_t'(seg),
    led_wide_t'(led), 0, NUM_DIGITS, DIGIT_W, NUM_LEDS));
  assign adv_slot = (DIGIT_W+1)'(slot_bits(seg_wide_t'(sh_seg),
    led_wide_t'(sh_led), int'(s_next), NUM_DIGITS, DIGIT_W, NUM_LEDS));

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= CNT_MAX;
      busy   <= 1'b0;
      valid  <= 1'b0;
      last   <= 1'b0;
      s      <= '0;
      data   <= '0;
      sh_seg <= '0;
      sh_led <= '0;
    end else if (step_p) begin
      // A step on the expiry cycle wins, so busy never drops here
      cnt   <= '0;
      busy  <= 1'b1;
      valid <= 1'b1;
      if (capture) begin
        sh_seg <= seg;
        sh_led <= led;
        s      <= '0;
        data   <= cap_slot;
        last   <= (NSLOTS == 1);
      end else begin
        s    <= s_next;
        data <= adv_slot;
        last <= (s_next == LAST_IDX);
      end
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_MAX - CNT_W'(1)) begin
        busy  <= 1'b0;
        valid <= 1'b0;
        last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_panel_snapshot_reader.sv
// Scoreboard bench: two reader configurations (16x16 and 8-digit/12-LED),
// expected slots queued at stimulus time and checked on every output change.
module tb_panel_snapshot_reader;

  localparam int TO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        step_a, step_b;
  logic [63:0] seg_a;
  logic [15:0] led_a;
  logic [31:0] seg_b;
  logic [11:0] led_b;
  logic [4:0]  data_a, data_b;
  logic [3:0]  s_a, s_b;
  logic        valid_a, last_a, busy_a;
  logic        valid_b, last_b, busy_b;

  panel_snapshot_reader #(
    .NUM_DIGITS(16), .DIGIT_W(4), .NUM_LEDS(16),
    .IDLE_TIMEOUT(TO), .SYNC_STAGES(2)
  ) dut_a (
    .clk_100mhz(clk), .rst_n(rst_n), .step(step_a),
    .seg(seg_a), .led(led_a), .data(data_a), .s(s_a),
    .valid(valid_a), .last(last_a), .busy(busy_a)
  );

  panel_snapshot_reader #(
    .NUM_DIGITS(8), .DIGIT_W(4), .NUM_LEDS(12),
    .IDLE_TIMEOUT(TO), .SYNC_STAGES(2)
  ) dut_b (
    .clk_100mhz(clk), .rst_n(rst_n), .step(step_b),
    .seg(seg_b), .led(led_b), .data(data_b), .s(s_b),
    .valid(valid_b), .last(last_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [4:0] data;
    logic [3:0] s;
    logic       valid;
    logic       last;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int failures = 0;

  logic [63:0] m_seg [2];
  logic [15:0] m_led [2];
  logic [4:0]  m_data [2];
  int          m_idx [2];
  bit          m_busy [2];
  int          last_upd [2];
  int          ev_cnt [2];
  int          cyc = 0;
  bit          watch = 1'b0;
  int          drops = 0;
  logic [11:0] prev_a, prev_b;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_slot(input logic [63:0] sg,
    input logic [15:0] ld, input int k, input int nd, input int nl);
    logic [3:0] d;
    logic       b;
    d = 4'h0;
    b = 1'b0;
    if (k < nd) d = sg[(nd-1-k)*4 +: 4];
    if (k < nl) b = ld[nl-1-k];
    return {d, b};
  endfunction

  task automatic push(input int w, input exp_t e);
    if (w == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic model_step(input int w);
    exp_t e;
    int   nd, nl, nsl;
    nd  = (w == 0) ? 16 : 8;
    nl  = (w == 0) ? 16 : 12;
    nsl = (w == 0) ? 16 : 12;
    if (!m_busy[w] || m_idx[w] == nsl - 1) begin
      m_seg[w] = (w == 0) ? seg_a : {32'h0, seg_b};
      m_led[w] = (w == 0) ? led_a : {4'h0, led_b};
      m_idx[w] = 0;
    end else begin
      m_idx[w]++;
    end
    m_busy[w] = 1'b1;
    e.data  = exp_slot(m_seg[w], m_led[w], m_idx[w], nd, nl);
    e.s     = m_idx[w][3:0];
    e.valid = 1'b1;
    e.last  = (m_idx[w] == nsl - 1);
    e.busy  = 1'b1;
    e.tmo   = 1'b0;
    m_data[w] = e.data;
    push(w, e);
  endtask

  task automatic model_timeout(input int w);
    exp_t e;
    m_busy[w] = 1'b0;
    e.data  = m_data[w];
    e.s     = m_idx[w][3:0];
    e.valid = 1'b0;
    e.last  = 1'b0;
    e.busy  = 1'b0;
    e.tmo   = 1'b1;
    push(w, e);
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_busy[w] = 1'b0;
      m_idx[w]  = 0;
      m_data[w] = '0;
    end
  endtask

  task automatic check_ev(input int w, input logic [11:0] cur);
    exp_t        e;
    logic [11:0] ev;
    checks++;
    if ((w == 0 && q_a.size() == 0) || (w == 1 && q_b.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_event dut%0d actual=%h expected=none",
               w, cur);
      return;
    end
    e  = (w == 0) ? q_a.pop_front() : q_b.pop_front();
    ev = {e.data, e.s, e.valid, e.last, e.busy};
    if (cur !== ev) begin
      failures++;
      $display("FAIL slot_event dut%0d actual=%h expected=%h", w, cur, ev);
    end
    if (e.tmo) begin
      checks++;
      if (cyc - last_upd[w] != TO) begin
        failures++;
        $display("FAIL timeout_delay dut%0d actual=%0d expected=%0d",
                 w, cyc - last_upd[w], TO);
      end
    end else begin
      last_upd[w] = cyc;
    end
  endtask

  always @(posedge clk) begin
    logic [11:0] cur_a, cur_b;
    #1;
    cyc++;
    if (!rst_n) begin
      prev_a = '0;
      prev_b = '0;
    end else begin
      cur_a = {data_a, s_a, valid_a, last_a, busy_a};
      cur_b = {data_b, s_b, valid_b, last_b, busy_b};
      if (cur_a !== prev_a) begin
        ev_cnt[0]++;
        check_ev(0, cur_a);
      end
      if (cur_b !== prev_b) begin
        ev_cnt[1]++;
        check_ev(1, cur_b);
      end
      prev_a = cur_a;
      prev_b = cur_b;
      if (watch && !busy_a) drops++;
    end
  end

  task automatic pulse(input int w);
    @(negedge clk);
    if (w == 0) step_a = 1'b1;
    else step_b = 1'b1;
    repeat (3) @(negedge clk);
    if (w == 0) step_a = 1'b0;
    else step_b = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_step(input int w);
    model_step(w);
    pulse(w);
  endtask

  initial begin
    int snap;
    rst_n  = 1'b0;
    step_a = 1'b0;
    step_b = 1'b0;
    seg_a  = 64'h0123_4567_89AB_CDEF;
    led_a  = 16'hA5A5;
    seg_b  = 32'h1234_5678;
    led_b  = 12'hC3A;
    ev_cnt[0] = 0;
    ev_cnt[1] = 0;
    last_upd[0] = 0;
    last_upd[1] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_a", {data_a, s_a, valid_a, last_a, busy_a}, 0);
    chk("reset_b", {data_b, s_b, valid_b, last_b, busy_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First capture with exact latency: sampled edge + 3 more edges
    model_step(0);
    @(negedge clk);
    step_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("latency_early_valid", valid_a, 0);
    @(posedge clk);
    #1;
    chk("first_slot", {data_a, s_a, valid_a, busy_a}, {5'b00001, 4'd0, 2'b11});
    @(negedge clk);
    step_a = 1'b0;
    repeat (6) @(negedge clk);

    // Live bus changes must not leak into the frame
    seg_a = 64'hFEDC_BA98_7654_3210;
    led_a = 16'h0000;
    for (int i = 0; i < 15; i++) do_step(0);
    chk("slot15", {data_a, s_a, last_a}, {5'b11111, 4'd15, 1'b1});
    do_step(0);
    chk("wrap_recapture", {data_a, s_a, last_a}, {5'b11110, 4'd0, 1'b0});

    // Idle timeout at s=5
    for (int i = 0; i < 5; i++) do_step(0);
    model_timeout(0);
    repeat (TO + 10) @(negedge clk);
    chk("timeout_state", {s_a, valid_a, busy_a}, {4'd5, 2'b00});
    do_step(0);
    chk("capture_after_timeout", {s_a, valid_a}, {4'd0, 1'b1});

    // Second step lands on the expiry cycle
    model_step(0);
    @(negedge clk);
    step_a = 1'b1;
    repeat (3) @(negedge clk);
    step_a = 1'b0;
    repeat (2) @(negedge clk);
    watch = 1'b1;
    repeat (95) @(negedge clk);
    model_step(0);
    step_a = 1'b1;
    repeat (3) @(negedge clk);
    step_a = 1'b0;
    repeat (10) @(negedge clk);
    watch = 1'b0;
    chk("aligned_busy_drops", drops, 0);
    chk("aligned_advance", {s_a, busy_a}, {4'd2, 1'b1});
    model_timeout(0);

    // 8 digits, 12 LEDs
    for (int i = 0; i < 13; i++) begin
      do_step(1);
      if (i == 0) chk("b_slot0", data_b, 5'b00011);
      if (i == 8) chk("b_slot8", data_b, 5'b00001);
      if (i == 9) chk("b_slot9", data_b, 5'b00000);
      if (i == 10) chk("b_slot10", data_b, 5'b00001);
      if (i == 11) chk("b_slot11", {data_b, s_b, last_b}, {5'b0, 4'd11, 1'b1});
      if (i == 12) chk("b_wrap", {s_b, last_b, valid_b}, {4'd0, 1'b0, 1'b1});
    end
    model_timeout(1);
    repeat (TO + 20) @(negedge clk);

    // Reset mid-frame with step held high
    do_step(0);
    do_step(0);
    @(negedge clk);
    step_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_a", {data_a, s_a, valid_a, last_a, busy_a}, 0);
    chk("reset_mid_b", {data_b, s_b, valid_b, last_b, busy_b}, 0);
    model_reset();
    repeat (3) @(negedge clk);
    snap = ev_cnt[0];
    model_step(0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_step_capture", {data_a, s_a, valid_a}, {5'b11110, 4'd0, 1'b1});
    step_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_step_once", ev_cnt[0] - snap, 1);
    model_timeout(0);
    repeat (TO + 10) @(negedge clk);

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
